// File: rtl/unsigned_calc_inv_v_if.sv
// Request/result bundle for the inverse 7a-3b+6c searcher.
// o_count exists only when UNSIGNED_CALC_INV_COUNT_EN is defined.
interface unsigned_calc_inv_v_if;
    logic              i_start;
    logic signed [8:0] i_fs;
    logic              o_busy;
    logic              o_done;
    logic              o_found;
    logic [3:0]        o_au;
    logic [3:0]        o_bu;
    logic [3:0]        o_cu;
`ifdef UNSIGNED_CALC_INV_COUNT_EN
    logic [8:0]        o_count;
`endif

    modport master (
        output i_start, i_fs,
        input  o_busy, o_done, o_found, o_au, o_bu, o_cu
`ifdef UNSIGNED_CALC_INV_COUNT_EN
        , input o_count
`endif
    );

    modport slave (
        input  i_start, i_fs,
        output o_busy, o_done, o_found, o_au, o_bu, o_cu
`ifdef UNSIGNED_CALC_INV_COUNT_EN
        , output o_count
`endif
    );
endinterface

// File: rtl/unsigned_calc_inv_v.sv
// Exhaustive inverse search of F = 7a-3b+6c over 4-bit a,b,c, one candidate per clock.
// UNSIGNED_CALC_INV_COUNT_EN: full scan always, also reports the number of matches on o_count.
module unsigned_calc_inv_v (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    unsigned_calc_inv_v_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

    state_t            r_state;
    logic [11:0]       r_n;
    logic signed [8:0] r_target;
    logic              r_busy;
    logic              r_done;
    logic              r_found;
    logic [3:0]        r_au;
    logic [3:0]        r_bu;
    logic [3:0]        r_cu;

    function automatic logic signed [8:0] calc_fwd(input logic [3:0] a,
                                                   input logic [3:0] b,
                                                   input logic [3:0] c);
        logic signed [8:0] sa, sb, sc;
        sa = $signed({5'b0, a});
        sb = $signed({5'b0, b});
        sc = $signed({5'b0, c});
        return (9'sd7 * sa) - (9'sd3 * sb) + (9'sd6 * sc);
    endfunction

    logic signed [8:0] w_cand;
    logic              w_match;
    logic              w_last;

    assign w_cand  = calc_fwd(r_n[11:8], r_n[7:4], r_n[3:0]);
    assign w_match = (w_cand == r_target);
    assign w_last  = (r_n == 12'd4095);

`ifdef UNSIGNED_CALC_INV_COUNT_EN
    // First-match candidate is tracked separately so the visible outputs hold until DONE.
    logic       r_hit;
    logic [3:0] r_fa, r_fb, r_fc;
    logic [8:0] r_cnt;
    logic [8:0] r_count;
    logic       w_hit_nxt;
    logic [3:0] w_fa, w_fb, w_fc;
    logic [8:0] w_cnt_nxt;

    always_comb begin
        w_hit_nxt = r_hit | w_match;
        w_fa      = r_hit ? r_fa : r_n[11:8];
        w_fb      = r_hit ? r_fb : r_n[7:4];
        w_fc      = r_hit ? r_fc : r_n[3:0];
        w_cnt_nxt = r_cnt + {8'b0, w_match};
    end

    assign bus.o_count = r_count;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_n      <= '0;
            r_target <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_au     <= '0;
            r_bu     <= '0;
            r_cu     <= '0;
`ifdef UNSIGNED_CALC_INV_COUNT_EN
            r_hit    <= 1'b0;
            r_fa     <= '0;
            r_fb     <= '0;
            r_fc     <= '0;
            r_cnt    <= '0;
            r_count  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.i_start) begin
                        r_target <= bus.i_fs;
                        r_n      <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_SEARCH;
`ifdef UNSIGNED_CALC_INV_COUNT_EN
                        r_hit    <= 1'b0;
                        r_cnt    <= '0;
`endif
                    end
                end
                S_SEARCH: begin
`ifdef UNSIGNED_CALC_INV_COUNT_EN
                    r_hit <= w_hit_nxt;
                    r_fa  <= w_fa;
                    r_fb  <= w_fb;
                    r_fc  <= w_fc;
                    r_cnt <= w_cnt_nxt;
                    if (w_last) begin
                        r_found <= w_hit_nxt;
                        r_au    <= w_hit_nxt ? w_fa : 4'd0;
                        r_bu    <= w_hit_nxt ? w_fb : 4'd0;
                        r_cu    <= w_hit_nxt ? w_fc : 4'd0;
                        r_count <= w_cnt_nxt;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_n <= r_n + 12'd1;
                    end
`else
                    if (w_match) begin
                        r_found <= 1'b1;
                        r_au    <= r_n[11:8];
                        r_bu    <= r_n[7:4];
                        r_cu    <= r_n[3:0];
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_last) begin
                        r_found <= 1'b0;
                        r_au    <= '0;
                        r_bu    <= '0;
                        r_cu    <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_n <= r_n + 12'd1;
                    end
`endif
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_busy  = r_busy;
    assign bus.o_done  = r_done;
    assign bus.o_found = r_found;
    assign bus.o_au    = r_au;
    assign bus.o_bu    = r_bu;
    assign bus.o_cu    = r_cu;
endmodule

// File: tb/tb_unsigned_calc_inv_v.sv
// Randomized and directed bench for unsigned_calc_inv_v against a brute-force arithmetic model.
module tb_unsigned_calc_inv_v;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 i_clk = ~i_clk;

    unsigned_calc_inv_v_if bus ();

    unsigned_calc_inv_v dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    // Reference: try every (a,b,c) with plain integer arithmetic, lowest {a,b,c} first.
    task automatic model(input int fs, output logic [12:0] exp_res, output int lat,
                         output int cnt);
        bit found = 0;
        int n_first = 0;
        exp_res = '0;
        cnt = 0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 16; c++)
                    if (7*a - 3*b + 6*c == fs) begin
                        cnt++;
                        if (!found) begin
                            found   = 1;
                            n_first = a*256 + b*16 + c;
                            exp_res = {1'b1, 4'(a), 4'(b), 4'(c)};
                        end
                    end
        lat = found ? n_first + 1 : 4096;
`ifdef UNSIGNED_CALC_INV_COUNT_EN
        lat = 4096;
`endif
    endtask

    task automatic run_search(input int fs, input int pulse_at, output int done_cyc,
                              output int busy_cyc, output logic [12:0] early,
                              output logic [12:0] res, output logic busy_at_done,
                              output logic done_again, output logic [8:0] cnt_o);
        @(negedge i_clk);
        bus.i_fs    = 9'(fs);
        bus.i_start = 1'b1;
        @(posedge i_clk); #1;
        bus.i_start = 1'b0;
        early    = {bus.o_found, bus.o_au, bus.o_bu, bus.o_cu};
        busy_cyc = bus.o_busy ? 1 : 0;
        done_cyc = -1;
        for (int k = 1; k <= 5000; k++) begin
            if (k == pulse_at) begin
                bus.i_start = 1'b1;
                bus.i_fs    = 9'($urandom);
            end else begin
                bus.i_start = 1'b0;
            end
            @(posedge i_clk); #1;
            if (bus.o_done) begin
                done_cyc = k;
                break;
            end
            if (bus.o_busy) busy_cyc++;
        end
        bus.i_start  = 1'b0;
        res          = {bus.o_found, bus.o_au, bus.o_bu, bus.o_cu};
        busy_at_done = bus.o_busy;
`ifdef UNSIGNED_CALC_INV_COUNT_EN
        cnt_o = bus.o_count;
`else
        cnt_o = '0;
`endif
        @(posedge i_clk); #1;
        done_again = bus.o_done | bus.o_busy;
    endtask

    task automatic check_search(input string name, input int fs, input int pulse_at);
        logic [12:0] exp_res, early, res;
        int lat, cnt, done_cyc, busy_cyc;
        logic busy_at_done, done_again;
        logic [8:0] cnt_o;
        model(fs, exp_res, lat, cnt);
        run_search(fs, pulse_at, done_cyc, busy_cyc, early, res, busy_at_done, done_again, cnt_o);
        n_tests++;
        if (done_cyc !== lat) begin
            n_fail++;
            $display("FAIL %s latency fs=%0d: got %0d want %0d", name, fs, done_cyc, lat);
        end
        n_tests++;
        if (res !== exp_res) begin
            n_fail++;
            $display("FAIL %s result fs=%0d: got %h want %h", name, fs, res, exp_res);
        end
        n_tests++;
        if (busy_cyc !== lat || busy_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy fs=%0d: got %0d cycles (at done %b) want %0d (0)",
                     name, fs, busy_cyc, busy_at_done, lat);
        end
        n_tests++;
        if (done_again !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse fs=%0d: got extra done/busy %b want 0", name, fs, done_again);
        end
`ifdef UNSIGNED_CALC_INV_COUNT_EN
        n_tests++;
        if (cnt_o !== 9'(cnt)) begin
            n_fail++;
            $display("FAIL %s count fs=%0d: got %0d want %0d", name, fs, cnt_o, cnt);
        end
`endif
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        bus.i_start = 1'b0;
        bus.i_fs    = '0;
        i_rst_n     = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        obs = {bus.o_busy, bus.o_done, bus.o_found, bus.o_au, bus.o_bu, bus.o_cu, 1'b0};
        n_tests++;
        if (obs !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0000", obs);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        n_tests++;
        if ({bus.o_busy, bus.o_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: got busy/done %b%b want 00", bus.o_busy, bus.o_done);
        end
    endtask

    task automatic test_directed();
        check_search("zero", 0, 0);
        check_search("one", 1, 0);
        check_search("min", -45, 0);
        check_search("max", 195, 0);
        check_search("above", 200, 0);
        check_search("below", -46, 0);
    endtask

    task automatic test_start_ignored();
        check_search("restart_ignored", 1, 50);
        check_search("restart_ignored_miss", 200, 1000);
    endtask

    task automatic test_hold();
        logic [12:0] early, res;
        int done_cyc, busy_cyc;
        logic busy_at_done, done_again;
        logic [8:0] cnt_o;
        run_search(1, 0, done_cyc, busy_cyc, early, res, busy_at_done, done_again, cnt_o);
        run_search(-46, 0, done_cyc, busy_cyc, early, res, busy_at_done, done_again, cnt_o);
        n_tests++;
        if (early !== {1'b1, 4'd1, 4'd2, 4'd0}) begin
            n_fail++;
            $display("FAIL hold_after_start: got %h want %h", early, {1'b1, 4'd1, 4'd2, 4'd0});
        end
    endtask

    task automatic test_abort_reset();
        logic [15:0] obs;
        logic saw_done = 1'b0;
        @(negedge i_clk);
        bus.i_fs    = 9'sd1;
        bus.i_start = 1'b1;
        @(negedge i_clk);
        bus.i_start = 1'b0;
        repeat (99) @(negedge i_clk);
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        obs = {bus.o_busy, bus.o_done, bus.o_found, bus.o_au, bus.o_bu, bus.o_cu, 1'b0};
        n_tests++;
        if (obs !== 16'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: got %h want 0000", obs);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(posedge i_clk); #1;
            if (bus.o_done || bus.o_busy) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got activity %b want 0", saw_done);
        end
        check_search("after_abort", 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            int fs;
            fs = int'($urandom_range(0, 270)) - 60;
            check_search("random", fs, 0);
        end
    endtask

`ifdef UNSIGNED_CALC_INV_COUNT_EN
    task automatic test_count();
        logic [12:0] early, res;
        int done_cyc, busy_cyc;
        logic busy_at_done, done_again;
        logic [8:0] cnt_o;
        run_search(0, 0, done_cyc, busy_cyc, early, res, busy_at_done, done_again, cnt_o);
        n_tests++;
        if (cnt_o !== 9'd14 || res !== 13'h1000 || done_cyc !== 4096) begin
            n_fail++;
            $display("FAIL count_zero: got count=%0d res=%h done=%0d want 14 1000 4096",
                     cnt_o, res, done_cyc);
        end
    endtask
`endif

    initial begin
        bus.i_start = 1'b0;
        bus.i_fs    = '0;
        test_reset();
        test_directed();
        test_start_ignored();
        test_hold();
        test_abort_reset();
        test_random();
`ifdef UNSIGNED_CALC_INV_COUNT_EN
        test_count();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
